// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte stream in, instruction-memory byte write port and CPU control out.
// slave = loader, master = host/stream source and memory/CPU side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  reload;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Purpose: writes a big-endian length-prefixed byte image into instruction memory, holding the CPU in reset until done.
// Latency: each accepted payload byte is written one cycle later; in_ready depends on state only.
// Backpressure: in_ready drops in DONE/ERR. Macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam logic [16:0] LP_MAX_WORDS = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_xsum;
`endif

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic [17:0]           w_last_idx;
    logic                  w_last;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_len_full = {r_len[15:8], bus.in_data};
    assign w_last_idx = {r_len, 2'b00} - 18'd1;
    assign w_last     = (18'(r_cnt) == w_last_idx);

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HDR_HI;
            r_len       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xsum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= bus.in_data;
                        r_state     <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= bus.in_data;
                        r_cnt      <= '0;
                        if ({1'b0, w_len_full} > LP_MAX_WORDS) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt;
                        r_mem_wdata <= bus.in_data;
                        r_cnt       <= r_cnt + ADDR_WIDTH'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xsum      <= r_xsum ^ bus.in_data;
`endif
                        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_xsum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // One cycle in DONE lets the final write land before the CPU is released.
                    r_cpu_hold <= 1'b0;
                    if (bus.reload) begin
                        r_state    <= S_HDR_HI;
                        r_len      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xsum     <= '0;
`endif
                    end
                end
                S_ERR: begin
                    if (bus.reload) begin
                        r_state    <= S_HDR_HI;
                        r_len      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xsum     <= '0;
`endif
                    end
                end
                default: begin
                    r_state    <= S_ERR;
                    r_in_ready <= 1'b0;
                    r_error    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table rows, directed corner sequences and random images against a stream-level model.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int AW   = 10;
    localparam int MAXW = 256;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int len;
        int vmode;
        bit exp_ok;
        int exp_writes;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
    imem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t tbl [8] = '{
        '{2,     0, 1'b1, 8},
        '{2,     1, 1'b1, 8},
        '{257,   0, 1'b0, 0},
        '{0,     0, 1'b1, 0},
        '{1,     2, 1'b1, 4},
        '{256,   2, 1'b1, 1024},
        '{5,     1, 1'b1, 20},
        '{65535, 1, 1'b0, 0}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Image = 16-bit big-endian word count, 4*len payload bytes, optional XOR byte.
    task automatic build(input int len, input bit bad_chk, output bq_t s);
        logic [15:0] l16;
        logic [7:0]  b;
        logic [7:0]  x;
        s   = {};
        l16 = len[15:0];
        x   = 8'h00;
        s.push_back(l16[15:8]);
        s.push_back(l16[7:0]);
        if (len <= MAXW) begin
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                s.push_back(b);
            end
            x = bad_chk ? ~x : x;
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(x);
`endif
        end
    endtask

    function automatic bit model_ok(input bq_t s);
        int len;
        len = int'({s[0], s[1]});
        if (len > MAXW) return 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < 4 * len; i++) x = x ^ s[2 + i];
            return (s.size() > 2 + 4 * len) && (s[2 + 4 * len] == x);
        end
`else
        return 1'b1;
`endif
    endfunction

    // vmode 0: valid held, 1: valid every other cycle, 2: random valid plus stray reload pulses.
    task automatic run_stream(input string name, input bq_t s, input int vmode,
                              input bit exp_ok, input int exp_writes);
        int idx, cyc, nw, bad, len, budget;
        bit pend, v;
        logic [AW-1:0] paddr;
        logic [7:0]    pdata;
        len    = int'({s[0], s[1]});
        budget = 4 * s.size() + 50;
        idx = 0; cyc = 0; nw = 0; bad = 0; pend = 1'b0;
        paddr = '0; pdata = '0;
        while (idx < s.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_we !== pend) bad++;
            else if (pend && (bus.mem_addr !== paddr || bus.mem_wdata !== pdata)) bad++;
            if (bus.mem_we === 1'b1) nw++;
            pend = 1'b0;
            case (vmode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? s[idx] : 8'($urandom);
            bus.reload   = (vmode == 2) && ($urandom_range(0, 7) == 0);
            if (v && bus.in_ready === 1'b1) begin
                if (idx >= 2 && idx < 2 + 4 * len && len <= MAXW) begin
                    pend  = 1'b1;
                    paddr = AW'(idx - 2);
                    pdata = s[idx];
                end
                idx++;
            end
        end
        check({name, " bytes accepted"}, idx, s.size());
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        if (bus.mem_we !== pend) bad++;
        else if (pend && (bus.mem_addr !== paddr || bus.mem_wdata !== pdata)) bad++;
        if (bus.mem_we === 1'b1) nw++;
        check({name, " done"},             bus.done,     exp_ok);
        check({name, " error"},            bus.error,    !exp_ok);
        check({name, " cpu_hold at end"},  bus.cpu_hold, 1);
        check({name, " in_ready at end"},  bus.in_ready, 0);
        @(negedge clk);
        if (bus.mem_we !== 1'b0) bad++;
        check({name, " cpu_hold after"},   bus.cpu_hold, !exp_ok);
        check({name, " write trace"},      bad,          0);
        check({name, " write count"},      nw,           exp_writes);
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        check({name, " reload in_ready"}, bus.in_ready, 1);
        check({name, " reload done"},     bus.done,     0);
        check({name, " reload error"},    bus.error,    0);
        check({name, " reload cpu_hold"}, bus.cpu_hold, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " in_ready"},  bus.in_ready,  1);
        check({name, " mem_we"},    bus.mem_we,    0);
        check({name, " mem_addr"},  bus.mem_addr,  0);
        check({name, " mem_wdata"}, bus.mem_wdata, 0);
        check({name, " cpu_hold"},  bus.cpu_hold,  1);
        check({name, " done"},      bus.done,      0);
        check({name, " error"},     bus.error,     0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        bq_t plan;
        bit  ok;
        int  len;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.reload   = 1'b0;
        #3;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            build(tbl[r].len, 1'b0, s);
            run_stream($sformatf("row%0d", r), s, tbl[r].vmode, tbl[r].exp_ok, tbl[r].exp_writes);
            do_reload($sformatf("row%0d", r));
        end

        plan = {8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        plan.push_back(8'h34);
`endif
        run_stream("plan held", plan, 0, 1'b1, 8);
        do_reload("plan held");
        run_stream("plan toggle", plan, 1, 1'b1, 8);
        do_reload("plan toggle");

        s = {8'h01, 8'h01};
        run_stream("overflow", s, 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("overflow still held", bus.cpu_hold, 1);
        do_reload("overflow");
        build(1, 1'b0, s);
        run_stream("after overflow", s, 0, 1'b1, 4);
        do_reload("after overflow");

        // Abort mid-payload: reset must take effect between clock edges.
        s = {8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        foreach (s[i]) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("midload write seen", bus.mem_we, 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("midload reset");
        @(negedge clk);
        reset = 1'b0;
        run_stream("after reset", plan, 0, 1'b1, 8);
        do_reload("after reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_stream("chk good", s, 0, 1'b1, 4);
        do_reload("chk good");
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run_stream("chk bad", s, 0, 1'b0, 4);
        do_reload("chk bad");
        s = {8'h00, 8'h00, 8'h01};
        run_stream("chk empty bad", s, 0, 1'b0, 0);
        do_reload("chk empty bad");
`endif

        for (int t = 0; t < 6; t++) begin
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(257, 400))
                                              : int'($urandom_range(0, 64));
            build(len, ($urandom_range(0, 3) == 0), s);
            ok = model_ok(s);
            run_stream($sformatf("rand%0d", t), s, int'($urandom_range(0, 2)), ok,
                       (len <= MAXW) ? 4 * len : 0);
            do_reload($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
